gate_sweep_checker: RTL and testbench
=====================================

Name: gate_sweep_checker

Overview:
Self-checking stimulus/response stage for the universal-gate library (NAND- and NOR-built NOT/AND/OR/NOR/NAND/XOR/XNOR).
- Drives the shared 2-bit input pair of the 12 gate instances through an exhaustive sweep.
- Samples their 12 outputs after a programmable settle time and compares them against an internally computed golden truth table.
- Reports per-output and per-vector failures with a start/busy/done handshake.
- Replaces hand-timed `#delay` stimulus with a synthesizable, clocked sweep.

Parameters:
- SETTLE, 2, number of cycles each input vector is held before sampling; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  sweep request; sampled only in IDLE or DONE.
- dut_in1  output  1  gate input A.
- dut_in2  output  1  gate input B.
- dut_out  input  12  gate outputs. Bit map:
  - b0 not_nand(A), b1 and_nand, b2 or_nand, b3 nor_nand, b4 xor_nand, b5 xnor_nand
  - b6 not_nor(B), b7 and_nor, b8 or_nor, b9 nand_nor, b10 xor_nor, b11 xnor_nor
- busy  output  1  sweep in progress.
- done  output  1  sweep complete; held until next accepted start.
- pass  output  1  valid when done: 1 when no mismatch occurred.
- err_mask  output  12  sticky OR of mismatching output bits over the sweep.
- fail_vec  output  4  bit k set when vector k had any mismatch.

Behaviour:
- Reset (async, rst_n=0): state IDLE, dut_in1=dut_in2=0, busy=0, done=0, pass=0, err_mask=0, fail_vec=0, vector index=0, settle counter=0.
- Vector order, idx 0..3, {A,B} = 11, 10, 01, 00.
- Golden dut_out per vector:
  - 11 -> 12'h9A6
  - 10 -> 12'h754
  - 01 -> 12'h715
  - 00 -> 12'hA69
- States IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE with start=1 at an edge:
  - Go to SETTLE.
  - idx=0, {dut_in1,dut_in2}=11, cnt=0.
  - busy=1, done=0, pass=0, err_mask=0, fail_vec=0.
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE-1, go to CHECK.
  - Vector is held for exactly SETTLE cycles in this state.
- CHECK, one cycle. At its closing edge:
  - diff = dut_out XOR golden(idx).
  - err_mask |= diff.
  - fail_vec[idx] |= (diff != 0).
  - If idx<3: idx++, drive next vector, cnt=0, go to SETTLE.
  - If idx==3: go to DONE, busy=0, done=1, pass=(final err_mask==0), including the diff from this last check.
- Each vector occupies SETTLE+1 cycles.
  - Start accepted at edge E0 -> vector k is compared at edge E0+(k+1)(SETTLE+1).
  - done rises after edge E0+4(SETTLE+1). With SETTLE=2, that is edge 12.
- DONE: outputs hold, inputs stay at 00, until an accepted start.
- start while busy (SETTLE/CHECK) is ignored with no effect on the sweep.
- start held high continuously re-triggers a new sweep one cycle after each DONE entry.
- dut_out is sampled only in CHECK; glitches during SETTLE have no effect.
- rst_n asserted mid-sweep: all state and outputs go immediately to reset values. No partial results are retained, and no done pulse occurs.
- All outputs are registered; no combinational path from dut_out or start to any output.

Test Plan:
- Correct 12 gate instances, SETTLE=2, start pulse at edge 0:
  - busy=1 for edges 1..12.
  - done=1 and pass=1 after edge 12.
  - err_mask=0, fail_vec=0.
  - dut_in sequence 11,10,01,00, each held 3 cycles.
- dut_out[9] forced 0:
  - pass=0, err_mask=12'h200, fail_vec=4'b1110.
  - Vector 11 passes because its golden NAND is 0.
- dut_out[0] forced 1:
  - err_mask=12'h001, fail_vec=4'b0011.
- Reset mid-sweep: rst_n pulsed low during vector 2.
  - All outputs return to 0 immediately.
  - A subsequent start gives a clean full sweep with pass=1.
- start re-pulsed during SETTLE of vector 1: ignored; done still after edge 12.
- Restart from DONE after a failing sweep with faults removed:
  - err_mask and fail_vec clear on the accepting edge.
  - Final pass=1.
- SETTLE=1 build: done after edge 8, each vector held 2 cycles.

Source files
------------

// File: rtl/gate_sweep_checker_if.sv
// Stimulus/response bundle between the sweep checker and the gate array.
interface gate_sweep_checker_if;
  logic        start;
  logic        dut_in1;
  logic        dut_in2;
  logic [11:0] dut_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [11:0] err_mask;
  logic [3:0]  fail_vec;

  // Requester side: issues start, supplies gate outputs, observes results.
  modport master (
    output start, dut_out,
    input  dut_in1, dut_in2, busy, done, pass, err_mask, fail_vec
  );

  // Checker side.
  modport slave (
    input  start, dut_out,
    output dut_in1, dut_in2, busy, done, pass, err_mask, fail_vec
  );
endinterface

// File: rtl/gate_sweep_checker.sv
// Clocked exhaustive sweep of the 2-input universal-gate array with golden compare.
module gate_sweep_checker #(
  parameter int unsigned SETTLE = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  gate_sweep_checker_if.slave bus
);
  localparam int unsigned CNT_W = 4;
  localparam int unsigned OUT_W = 12;
  localparam int unsigned NVEC  = 4;
  localparam int unsigned IDX_W = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NVEC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  // Expected outputs of all 12 gates for the vector at sweep position idx.
  function automatic logic [OUT_W-1:0] golden(input logic [IDX_W-1:0] idx);
    logic [OUT_W-1:0] g;
    case (idx)
      2'd0:    g = 12'h9A6;
      2'd1:    g = 12'h754;
      2'd2:    g = 12'h715;
      default: g = 12'hA69;
    endcase
    return g;
  endfunction

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         ab_q, ab_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [OUT_W-1:0]   err_q, err_d;
  logic [NVEC-1:0]    fv_q, fv_d;
  logic [OUT_W-1:0]   diff_c;

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      ab_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ab_q    <= ab_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
    end
  end

  // Next-state and next-output logic; vector {A,B} is the inverted sweep index.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ab_d    = ab_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fv_d    = fv_q;
    diff_c  = bus.dut_out ^ golden(idx_q);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_SETTLE;
          idx_d   = '0;
          cnt_d   = '0;
          ab_d    = 2'b11;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          fv_d    = '0;
        end
      end
      S_SETTLE: begin
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        err_d       = err_q | diff_c;
        fv_d[idx_q] = fv_q[idx_q] | (|diff_c);
        if (idx_q != IDX_LAST) begin
          idx_d   = IDX_W'(idx_q + 1'b1);
          ab_d    = ~IDX_W'(idx_q + 1'b1);
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.dut_in1  = ab_q[1];
  assign bus.dut_in2  = ab_q[0];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.err_mask = err_q;
  assign bus.fail_vec = fv_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Randomized bench for gate_sweep_checker: two builds (SETTLE=2 and SETTLE=1),
// a modelled gate array with injectable stuck-at faults and settle-time glitches.
module tb_gate_sweep_checker;
  logic clk;
  logic rst_n;
  logic [1:0]  start_r;
  logic [11:0] stuck0;
  logic [11:0] stuck1;
  logic [11:0] glitch;

  int n_vec;
  int n_err;

  localparam logic [1:0] VEC_AB [4] = '{2'b11, 2'b10, 2'b01, 2'b00};

  gate_sweep_checker_if if0 ();
  gate_sweep_checker_if if1 ();

  gate_sweep_checker #(.SETTLE(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  gate_sweep_checker #(.SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  // Ideal behaviour of the 12 gates in bit-map order.
  function automatic logic [11:0] gates(input logic a, input logic b);
    logic [11:0] g;
    g[0]  = ~a;      g[1]  = a & b;   g[2]  = a | b;
    g[3]  = ~(a | b); g[4] = a ^ b;   g[5]  = ~(a ^ b);
    g[6]  = ~b;      g[7]  = a & b;   g[8]  = a | b;
    g[9]  = ~(a & b); g[10] = a ^ b;  g[11] = ~(a ^ b);
    return g;
  endfunction

  // Gate array as seen by the checker: ideal gates with stuck-at faults.
  function automatic logic [11:0] faulty(input logic a, input logic b);
    return (gates(a, b) & ~stuck0) | stuck1;
  endfunction

  assign if0.start   = start_r[0];
  assign if1.start   = start_r[1];
  assign if0.dut_out = faulty(if0.dut_in1, if0.dut_in2) ^ glitch;
  assign if1.dut_out = faulty(if1.dut_in1, if1.dut_in2) ^ glitch;

  logic [1:0]  busy_w, done_w, pass_w;
  logic [1:0]  ab_w  [2];
  logic [11:0] err_w [2];
  logic [3:0]  fv_w  [2];

  always_comb begin
    busy_w   = {if1.busy, if0.busy};
    done_w   = {if1.done, if0.done};
    pass_w   = {if1.pass, if0.pass};
    ab_w[0]  = {if0.dut_in1, if0.dut_in2};
    ab_w[1]  = {if1.dut_in1, if1.dut_in2};
    err_w[0] = if0.err_mask;
    err_w[1] = if1.err_mask;
    fv_w[0]  = if0.fail_vec;
    fv_w[1]  = if1.fail_vec;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full sweep on instance sel. repulse_n: cycle after which start is pulsed
  // mid-sweep (-1 for none); hold: keep start high; skip_start: start already high.
  task automatic sweep(input int sel, input int repulse_n, input bit hold, input bit skip_start);
    int s, n_end;
    logic [11:0] exp_err, d;
    logic [3:0]  exp_fv, exp_st, got_st;
    logic        exp_pass;
    s = (sel == 1) ? 1 : 2;
    n_end = 4 * (s + 1);
    exp_err = '0;
    exp_fv  = '0;
    for (int k = 0; k < 4; k++) begin
      d = faulty(VEC_AB[k][1], VEC_AB[k][0]) ^ gates(VEC_AB[k][1], VEC_AB[k][0]);
      exp_err |= d;
      exp_fv[k] = (d != '0);
    end
    exp_pass = (exp_err == '0);
    if (!skip_start) start_r[sel] = 1'b1;
    glitch = 12'($urandom);
    @(posedge clk); #1;
    start_r[sel] = hold;
    for (int n = 0; n <= n_end; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      exp_st = {(n < n_end), (n == n_end), (n < n_end) ? VEC_AB[n / (s + 1)] : 2'b00};
      got_st = {busy_w[sel], done_w[sel], ab_w[sel]};
      n_vec++;
      if (got_st !== exp_st) begin
        n_err++;
        $display("FAIL status[%0d] cycle %0d: got busy/done/ab=%b expected %b", sel, n, got_st, exp_st);
      end
      if (n == 0) begin
        n_vec++;
        if ({pass_w[sel], err_w[sel], fv_w[sel]} !== 17'd0) begin
          n_err++;
          $display("FAIL clear_on_start[%0d]: got pass=%b err=%h fv=%b expected all 0",
                   sel, pass_w[sel], err_w[sel], fv_w[sel]);
        end
      end
      if (n == n_end) begin
        n_vec++;
        if (pass_w[sel] !== exp_pass) begin
          n_err++;
          $display("FAIL pass[%0d]: got %b expected %b", sel, pass_w[sel], exp_pass);
        end
        n_vec++;
        if (err_w[sel] !== exp_err) begin
          n_err++;
          $display("FAIL err_mask[%0d]: got %h expected %h", sel, err_w[sel], exp_err);
        end
        n_vec++;
        if (fv_w[sel] !== exp_fv) begin
          n_err++;
          $display("FAIL fail_vec[%0d]: got %b expected %b", sel, fv_w[sel], exp_fv);
        end
      end
      start_r[sel] = (n == repulse_n) ? 1'b1 : hold;
      glitch = (((n + 1) % (s + 1)) == 0) ? 12'h000 : 12'($urandom);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_r = '0;
    stuck0 = '0;
    stuck1 = '0;
    glitch = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if ({busy_w[i], done_w[i], pass_w[i], ab_w[i], err_w[i], fv_w[i]} !== 21'd0) begin
        n_err++;
        $display("FAIL reset_state[%0d]: got busy=%b done=%b pass=%b ab=%b err=%h fv=%b expected all 0",
                 i, busy_w[i], done_w[i], pass_w[i], ab_w[i], err_w[i], fv_w[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_clean();
    stuck0 = '0; stuck1 = '0;
    sweep(0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_stuck_faults();
    stuck0 = 12'h200; stuck1 = '0;
    sweep(0, -1, 1'b0, 1'b0);
    stuck0 = '0; stuck1 = 12'h001;
    sweep(0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_restart_after_fail();
    stuck0 = '0; stuck1 = '0;
    sweep(0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    stuck0 = 12'h010; stuck1 = '0;
    sweep(0, 3, 1'b0, 1'b0);
    stuck0 = '0;
    sweep(0, 4, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    stuck0 = '0; stuck1 = 12'h800;
    sweep(0, -1, 1'b1, 1'b0);
    stuck1 = '0;
    sweep(0, -1, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_sweep();
    stuck0 = 12'h00F; stuck1 = '0;
    start_r[0] = 1'b1;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    repeat (2 * 3 + 1) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy_w[0], done_w[0], pass_w[0], ab_w[0], err_w[0], fv_w[0]} !== 21'd0) begin
      n_err++;
      $display("FAIL mid_reset: got busy=%b done=%b pass=%b ab=%b err=%h fv=%b expected all 0",
               busy_w[0], done_w[0], pass_w[0], ab_w[0], err_w[0], fv_w[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({busy_w[0], done_w[0]} !== 2'b00) begin
      n_err++;
      $display("FAIL post_reset_idle: got busy=%b done=%b expected 0 0", busy_w[0], done_w[0]);
    end
    stuck0 = '0;
    sweep(0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      if (($urandom % 4) == 0) begin
        stuck0 = '0; stuck1 = '0;
      end else begin
        stuck0 = 12'($urandom) & 12'($urandom) & 12'($urandom);
        stuck1 = 12'($urandom) & 12'($urandom) & 12'($urandom);
      end
      sweep(int'($urandom % 2), -1, 1'b0, 1'b0);
      repeat (int'($urandom % 3)) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_settle1();
    stuck0 = '0; stuck1 = '0;
    sweep(1, -1, 1'b0, 1'b0);
    stuck0 = 12'h040; stuck1 = 12'h002;
    sweep(1, 2, 1'b0, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_clean();
    test_stuck_faults();
    test_restart_after_fail();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_sweep();
    test_settle1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
